// File: rtl/uart_pkg.sv
// Shared types and constants for the filtered UART receiver.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  // Two-of-three vote across the filter taps.
  function automatic logic majority3(input logic [2:0] taps);
    return (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sync_filter.sv
// Brings the asynchronous serial line into the clock domain and removes
// single-cycle glitches with a 3-tap majority vote.
module uart_rx_sync_filter
  import uart_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_vote
);

  logic       sync_meta;
  logic       sync_line;
  logic [2:0] taps;

  // Two-flop synchroniser followed by a 3-deep shift register; all stages
  // reset to the idle level so reset never looks like a start bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_meta <= LINE_IDLE;
      sync_line <= LINE_IDLE;
      taps      <= {3{LINE_IDLE}};
    end else begin
      // NOTE: non-blocking assignments let each stage take the previous
      // stage's old value, which is what builds the pipeline.
      sync_meta <= i_async;
      sync_line <= sync_meta;
      taps      <= {taps[1:0], sync_line};
    end
  end

  assign o_vote = majority3(taps);

endmodule

// File: rtl/uart_rx_filtered.sv
// 8N1 UART receiver with input filtering, framing-error detection and a
// held valid/ack handshake toward the byte consumer.
module uart_rx_filtered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_data_line,
  input  logic       i_data_ack,
  output logic [7:0] o_data_byte,
  output logic       o_data_valid,
  output logic       o_frame_error,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2 - 1;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  logic vote;

  rx_state_e              state, state_nxt;
  logic [CNT_W-1:0]       clk_cnt, clk_cnt_nxt;
  logic [2:0]             bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0]   shift, shift_nxt;
  logic [DATA_BITS-1:0]   data_byte, data_byte_nxt;
  logic                   data_valid, data_valid_nxt;
  logic                   frame_error_nxt, overrun_nxt;
  logic                   frame_error, overrun;

  uart_rx_sync_filter u_sync_filter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_rx_data_line),
    .o_vote  (vote)
  );

  // State, counters, assembled byte and handshake registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data_byte   <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_nxt;
      clk_cnt     <= clk_cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      shift       <= shift_nxt;
      data_byte   <= data_byte_nxt;
      data_valid  <= data_valid_nxt;
      frame_error <= frame_error_nxt;
      overrun     <= overrun_nxt;
    end
  end

  // Frame sequencing on the filtered line plus the consumer handshake.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case statement can leave one unassigned (no latches).
    state_nxt       = state;
    clk_cnt_nxt     = clk_cnt;
    bit_idx_nxt     = bit_idx;
    shift_nxt       = shift;
    data_byte_nxt   = data_byte;
    data_valid_nxt  = data_valid;
    frame_error_nxt = 1'b0;
    overrun_nxt     = 1'b0;

    // Ack clears valid; a capture later in this block overrides it.
    if (i_data_ack) data_valid_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        if (!vote) begin
          state_nxt   = START;
          clk_cnt_nxt = '0;
        end
      end

      START: begin
        if (clk_cnt == HALF_CNT) begin
          clk_cnt_nxt = '0;
          if (!vote) begin
            state_nxt   = DATA;
            bit_idx_nxt = '0;
          end else begin
            state_nxt = IDLE;  // false start: no pulse
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (clk_cnt == LAST_CNT) begin
          clk_cnt_nxt        = '0;
          shift_nxt[bit_idx] = vote;
          if (bit_idx == LAST_BIT) state_nxt = STOP;
          else                     bit_idx_nxt = bit_idx + 3'd1;
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (clk_cnt == LAST_CNT) begin
          clk_cnt_nxt = '0;
          if (vote) begin
            data_byte_nxt  = shift;
            data_valid_nxt = 1'b1;
            overrun_nxt    = data_valid && !i_data_ack;
            state_nxt      = IDLE;
          end else begin
            frame_error_nxt = 1'b1;
            state_nxt       = WAIT_IDLE;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end

      WAIT_IDLE: begin
        // Hold off until the line is released so a break cannot retrigger.
        if (vote) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign o_data_byte   = data_byte;
  assign o_data_valid  = data_valid;
  assign o_frame_error = frame_error;
  assign o_overrun     = overrun;
  assign o_busy        = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_filtered.sv
// Self-checking bench for uart_rx_filtered: directed vector table, hand
// sequences for the multi-cycle corners, then randomized frames checked
// against a byte-level model of the receiver.
module tb_uart_rx_filtered;

  localparam int CPB  = 10;
  localparam int HALF = CPB / 2 - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_line;
  logic       data_ack;
  logic [7:0] data_byte;
  logic       data_valid;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  uart_rx_filtered #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_rx_data_line (rx_line),
    .i_data_ack     (data_ack),
    .o_data_byte    (data_byte),
    .o_data_valid   (data_valid),
    .o_frame_error  (frame_error),
    .o_overrun      (overrun),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Event counters maintained by the monitor only.
  int         ferr_cnt = 0;
  int         ovr_cnt  = 0;
  int         rise_cnt = 0;
  int         busy_cnt = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] ovr_byte = 8'h00;

  always @(negedge clk) begin
    if (frame_error) ferr_cnt++;
    if (overrun) begin
      ovr_cnt++;
      ovr_byte = data_byte;
    end
    if (data_valid && !prev_valid) rise_cnt++;
    if (busy) busy_cnt++;
    prev_valid = data_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ack_after;
    logic [7:0] exp_byte;
    logic       exp_valid;
    int         exp_ferr;
    int         exp_ovr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input logic glitch);
    for (int c = 0; c < CPB; c++) begin
      rx_line = (glitch && c == CPB / 2) ? ~b : b;
      tick();
    end
  endtask

  // Serialises one 8N1 frame; glitchy frames get random one-cycle spikes.
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic glitchy);
    drive_bit(1'b0, glitchy && $urandom_range(0, 2) == 0);
    for (int i = 0; i < 8; i++) drive_bit(data[i], glitchy && $urandom_range(0, 2) == 0);
    drive_bit(stop, glitchy && $urandom_range(0, 2) == 0);
    rx_line = 1'b1;
  endtask

  task automatic idle(input int n);
    rx_line = 1'b1;
    repeat (n) tick();
  endtask

  task automatic ack_pulse();
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    settle();
  endtask

  int         f0, o0, r0, b0;
  logic       m_valid;
  logic [7:0] m_byte;

  initial begin
    // Directed vectors: byte, stop level, ack afterwards, expected results.
    vecs[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 0, 0};
    vecs[1] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 0, 0};
    vecs[2] = '{8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 0, 1};
    vecs[3] = '{8'h81, 1'b0, 1'b0, 8'h22, 1'b0, 1, 0};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 0, 0};
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 0, 0};
    vecs[6] = '{8'hC3, 1'b0, 1'b1, 8'hFF, 1'b1, 1, 0};
    vecs[7] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 1'b1, 0, 0};

    rst      = 1'b1;
    rx_line  = 1'b1;
    data_ack = 1'b0;
    repeat (3) tick();
    settle();
    check("reset_byte", data_byte, 8'h00);
    check("reset_valid", data_valid, 0);
    check("reset_ferr", frame_error, 0);
    check("reset_ovr", overrun, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    idle(5);

    // Table-driven frames.
    for (int i = 0; i < 8; i++) begin
      f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(vecs[i].data, vecs[i].stop, 1'b0);
      idle(12);
      settle();
      check($sformatf("vec%0d_byte", i), data_byte, vecs[i].exp_byte);
      check($sformatf("vec%0d_valid", i), data_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_ovr", i), ovr_cnt - o0, vecs[i].exp_ovr);
      check($sformatf("vec%0d_busy", i), busy, 0);
      if (vecs[i].exp_ovr != 0) check($sformatf("vec%0d_ovr_byte", i), ovr_byte, vecs[i].exp_byte);
      if (vecs[i].ack_after) begin
        ack_pulse();
        check($sformatf("vec%0d_ack_clear", i), data_valid, 0);
      end
    end

    // Back-to-back frames, each acked in the cycle after valid rises.
    begin
      int         got_n;
      logic [7:0] got[2];
      logic       lp;
      got_n = 0; got[0] = 8'h00; got[1] = 8'h00; lp = data_valid;
      f0 = ferr_cnt; o0 = ovr_cnt;
      fork
        begin
          send_frame(8'hA5, 1'b1, 1'b0);
          send_frame(8'h3C, 1'b1, 1'b0);
          idle(12);
        end
        begin
          for (int c = 0; c < 260 && got_n < 2; c++) begin
            @(negedge clk); #1;
            if (data_valid && !lp) begin
              got[got_n] = data_byte;
              got_n++;
              data_ack = 1'b1;
              @(posedge clk); #1;
              data_ack = 1'b0;
            end
            lp = data_valid;
          end
        end
      join
      settle();
      check("b2b_count", got_n, 2);
      check("b2b_first", got[0], 8'hA5);
      check("b2b_second", got[1], 8'h3C);
      check("b2b_ovr", ovr_cnt - o0, 0);
      check("b2b_ferr", ferr_cnt - f0, 0);
      check("b2b_valid_end", data_valid, 0);
    end

    // Framing error followed by a held break.
    begin
      int drop;
      drop = 0;
      f0 = ferr_cnt; r0 = rise_cnt;
      drive_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(((8'h81 >> i) & 8'h01) != 0, 1'b0);
      drive_bit(1'b0, 1'b0);
      repeat (30) begin
        settle();
        if (!busy) drop++;
      end
      idle(10);
      settle();
      check("brk_ferr", ferr_cnt - f0, 1);
      check("brk_no_valid", rise_cnt - r0, 0);
      check("brk_busy_held", drop, 0);
      check("brk_busy_release", busy, 0);
      check("brk_valid", data_valid, 0);
    end

    // Single-cycle glitches, then a 3-cycle low pulse.
    idle(5);
    b0 = busy_cnt; r0 = rise_cnt; f0 = ferr_cnt;
    for (int g = 0; g < 4; g++) begin
      rx_line = 1'b0;
      tick();
      idle(15);
    end
    settle();
    check("glitch_busy", busy_cnt - b0, 0);
    b0 = busy_cnt;
    rx_line = 1'b0;
    repeat (3) tick();
    idle(30);
    settle();
    check("pulse_busy_bound", int'((busy_cnt - b0) <= HALF + 1), 1);
    check("pulse_busy_end", busy, 0);
    check("pulse_no_valid", rise_cnt - r0, 0);
    check("pulse_ferr", ferr_cnt - f0, 0);

    // Reset in the middle of 0xF0, then a clean 0x0F.
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(12);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b0);
    rx_line = 1'b1;
    repeat (CPB / 2) tick();
    rst = 1'b1;
    tick();
    settle();
    check("mid_rst_byte", data_byte, 8'h00);
    check("mid_rst_valid", data_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ferr", frame_error, 0);
    check("mid_rst_ovr", overrun, 0);
    rst = 1'b0;
    idle(40);
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h0F, 1'b1, 1'b0);
    idle(12);
    settle();
    check("post_rst_byte", data_byte, 8'h0F);
    check("post_rst_valid", data_valid, 1);
    check("post_rst_ferr", ferr_cnt - f0, 0);
    check("post_rst_ovr", ovr_cnt - o0, 0);
    ack_pulse();
    m_valid = 1'b0;
    m_byte  = 8'h0F;

    // Randomized frames against a byte-level model.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      logic       good;
      logic       glitchy;
      int         exp_ovr;
      int         exp_rise;
      d       = 8'($urandom);
      good    = $urandom_range(0, 99) < 85;
      glitchy = $urandom_range(0, 3) == 0;
      f0 = ferr_cnt; o0 = ovr_cnt; r0 = rise_cnt;
      send_frame(d, good, glitchy);
      idle($urandom_range(12, 25));
      settle();
      exp_ovr  = (good && m_valid) ? 1 : 0;
      exp_rise = (good && !m_valid) ? 1 : 0;
      if (good) begin
        m_valid = 1'b1;
        m_byte  = d;
      end
      check($sformatf("rnd%0d_byte", n), data_byte, m_byte);
      check($sformatf("rnd%0d_valid", n), data_valid, m_valid);
      check($sformatf("rnd%0d_ferr", n), ferr_cnt - f0, good ? 0 : 1);
      check($sformatf("rnd%0d_ovr", n), ovr_cnt - o0, exp_ovr);
      check($sformatf("rnd%0d_rise", n), rise_cnt - r0, exp_rise);
      check($sformatf("rnd%0d_busy", n), busy, 0);
      if ($urandom_range(0, 1) == 1) begin
        ack_pulse();
        m_valid = 1'b0;
        check($sformatf("rnd%0d_ack", n), data_valid, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
